// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced mode/inc buttons drive RUN / SET_H / SET_M time editing.
// Optional AUTO_REPEAT_EN macro adds auto-repeat of increments while inc is held.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 3,
`ifdef AUTO_REPEAT_EN
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE = 10,
`endif
  parameter int BLINK_PERIOD = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic [4:0] i_cur_hours,
  input  logic [5:0] i_cur_minutes,
  output logic       o_run_en,
  output logic       o_load,
  output logic [4:0] o_load_hours,
  output logic [5:0] o_load_minutes,
  output logic       o_blink_h,
  output logic       o_blink_m,
  output logic [1:0] o_mode
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET_H = 2'd1,
    S_SET_M = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_acc;
  logic [1:0] r_acc_d;
  logic [3:0] r_db_cnt [2];
  logic       r_run_en;
  logic       r_load;
  logic [4:0] r_load_hours;
  logic [5:0] r_load_minutes;
  logic [6:0] r_blink_cnt;
  logic       r_blink_ph;

  logic [1:0] w_btn;
  logic [1:0] w_ev;
  logic       w_mode_ev;
  logic       w_inc_ev;
  logic       w_rep_ev;
  logic       w_set;
  logic       w_inc_go;
  logic       w_blink_clr;

  // bit 0 = mode button, bit 1 = inc button
  assign w_btn = {i_btn_inc, i_btn_mode};

  // Synchronise both buttons and accept a level once it has held steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == 4'(DEBOUNCE_CYCLES)) begin
          r_acc[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Rising edge of an accepted level is the press event.
  assign w_ev      = r_acc & ~r_acc_d;
  assign w_mode_ev = w_ev[0];
  assign w_inc_ev  = w_ev[1];
  assign w_set     = (r_state == S_SET_H) || (r_state == S_SET_M);

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);

  logic [RPW-1:0] r_rep_cnt;
  logic           r_rep_act;
  logic           r_rep_ph;

  // Phase 0 waits the initial delay, phase 1 paces the repeat rate.
  assign w_rep_ev = r_rep_act & r_acc[1] & w_set &
                    (r_rep_cnt == (r_rep_ph ? RPW'(REPEAT_RATE)
                                            : RPW'(REPEAT_DELAY)));

  // Time held-inc repeats; any release, mode event or RUN stops them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_rep_ph  <= 1'b0;
    end else if (!w_set || w_mode_ev || !r_acc[1]) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_rep_ph  <= 1'b0;
    end else if (w_inc_ev) begin
      r_rep_cnt <= RPW'(1);
      r_rep_act <= 1'b1;
      r_rep_ph  <= 1'b0;
    end else if (w_rep_ev) begin
      r_rep_cnt <= RPW'(1);
      r_rep_ph  <= 1'b1;
    end else if (r_rep_act) begin
      r_rep_cnt <= r_rep_cnt + RPW'(1);
    end
  end
`else
  assign w_rep_ev = 1'b0;
`endif

  // Mode always wins over a same-cycle increment.
  assign w_inc_go    = (w_inc_ev | w_rep_ev) & w_set & ~w_mode_ev;
  assign w_blink_clr = w_mode_ev | w_inc_ev | w_rep_ev;

  // Blink half-phase timer, restarted low on edits and transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_blink_clr) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (r_blink_cnt == 7'(BLINK_PERIOD - 1)) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= ~r_blink_ph;
    end else begin
      r_blink_cnt <= r_blink_cnt + 7'd1;
    end
  end

  // Edit state machine with registered run/load controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_run_en       <= 1'b1;
      r_load         <= 1'b0;
      r_load_hours   <= '0;
      r_load_minutes <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_run_en <= 1'b1;
          if (w_mode_ev) begin
            r_state        <= S_SET_H;
            r_run_en       <= 1'b0;
            r_load_hours   <= i_cur_hours;
            r_load_minutes <= i_cur_minutes;
          end
        end
        S_SET_H: begin
          if (w_mode_ev) begin
            r_state <= S_SET_M;
          end else if (w_inc_go) begin
            r_load_hours <= (r_load_hours >= 5'd23) ? 5'd0
                          : r_load_hours + 5'd1;
          end
        end
        S_SET_M: begin
          if (w_mode_ev) begin
            r_state <= S_RUN;
            r_load  <= 1'b1;
          end else if (w_inc_go) begin
            r_load_minutes <= (r_load_minutes >= 6'd59) ? 6'd0
                            : r_load_minutes + 6'd1;
          end
        end
        default: begin
          r_state  <= S_RUN;
          r_run_en <= 1'b1;
        end
      endcase
    end
  end

  assign o_run_en       = r_run_en;
  assign o_load         = r_load;
  assign o_load_hours   = r_load_hours;
  assign o_load_minutes = r_load_minutes;
  assign o_mode         = r_state;
  assign o_blink_h      = (r_state == S_SET_H) & r_blink_ph;
  assign o_blink_m      = (r_state == S_SET_M) & r_blink_ph;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl.
// Mode changes and load strobes are matched against queued expectations.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0;
  logic       o_run_en;
  logic       o_load;
  logic [4:0] o_load_hours;
  logic [5:0] o_load_minutes;
  logic       o_blink_h;
  logic       o_blink_m;
  logic [1:0] o_mode;

  int errors = 0;
  int checks = 0;

  logic [1:0]  mode_q[$];
  logic [10:0] load_q[$];

  clock_set_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_btn_mode     (btn_mode),
    .i_btn_inc      (btn_inc),
    .i_cur_hours    (cur_h),
    .i_cur_minutes  (cur_m),
    .o_run_en       (o_run_en),
    .o_load         (o_load),
    .o_load_hours   (o_load_hours),
    .o_load_minutes (o_load_minutes),
    .o_blink_h      (o_blink_h),
    .o_blink_m      (o_blink_m),
    .o_mode         (o_mode)
  );

  always #5 clk = ~clk;

  task automatic mon_mode();
    logic [1:0] prev;
    logic [1:0] e;
    prev = 2'd0;
    forever begin
      @(negedge clk);
      if (o_mode !== prev) begin
        checks++;
        if (mode_q.size() == 0) begin
          errors++;
          $display("FAIL mode_change: got %0d, none expected", o_mode);
        end else begin
          e = mode_q.pop_front();
          if (o_mode !== e) begin
            errors++;
            $display("FAIL mode_change: got %0d, expected %0d", o_mode, e);
          end
        end
        prev = o_mode;
      end
    end
  endtask

  task automatic mon_load();
    logic        after;
    logic [10:0] e;
    after = 1'b0;
    forever begin
      @(negedge clk);
      if (after) begin
        checks++;
        if (o_load !== 1'b0 || o_run_en !== 1'b1) begin
          errors++;
          $display("FAIL load_end: load=%b run_en=%b, expected 0/1",
                   o_load, o_run_en);
        end
      end
      after = 1'b0;
      if (o_load === 1'b1) begin
        checks++;
        if (load_q.size() == 0) begin
          errors++;
          $display("FAIL load_pulse: unexpected load h=%0d m=%0d",
                   o_load_hours, o_load_minutes);
        end else begin
          e = load_q.pop_front();
          if ({o_load_hours, o_load_minutes} !== e || o_run_en !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: h=%0d m=%0d run_en=%b, expected h=%0d m=%0d run_en=0",
                     o_load_hours, o_load_minutes, o_run_en, e[10:6], e[5:0]);
          end
        end
        after = 1'b1;
      end
    end
  endtask

  task automatic press(input bit m, input bit i, input int len);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (len) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", o_mode, 0);
    chk("rst_run_en", o_run_en, 1);
    chk("rst_load", o_load, 0);
    chk("rst_lh", o_load_hours, 0);
    chk("rst_blink", {o_blink_h, o_blink_m}, 0);
    cur_h = 5'd3;
    cur_m = 6'd4;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    chk("seth_run_en", o_run_en, 0);
    chk("seth_lh", o_load_hours, 3);
    @(posedge clk);
    #2;
    mode_q.push_back(2'd0);
    rst = 1'b1;
    #1;
    chk("async_mode", o_mode, 0);
    chk("async_run_en", o_run_en, 1);
    chk("async_load", o_load, 0);
    chk("async_blink", {o_blink_h, o_blink_m}, 0);
    chk("async_lh", o_load_hours, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_debounce();
    cur_h = 5'd7;
    cur_m = 6'd30;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    chk("db_capture", o_load_hours, 7);
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    chk("db_short", o_load_hours, 7);
    btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    chk("db_n5", o_load_hours, 7);
    @(negedge clk);
    chk("db_n6", o_load_hours, 8);
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    chk("db_once", o_load_hours, 8);
    mode_q.push_back(2'd2);
    press(1'b1, 1'b0, 8);
    mode_q.push_back(2'd0);
    load_q.push_back({5'd8, 6'd30});
    press(1'b1, 1'b0, 8);
  endtask

  task automatic test_edit_sequence();
    cur_h = 5'd22;
    cur_m = 6'd58;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    chk("seq_run_en", o_run_en, 0);
    press(1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    chk("seq_h_wrap", o_load_hours, 0);
    mode_q.push_back(2'd2);
    press(1'b1, 1'b0, 8);
    chk("seq_run_en_m", o_run_en, 0);
    for (int n = 0; n < 3; n++) press(1'b0, 1'b1, 8);
    chk("seq_m_wrap", o_load_minutes, 1);
    mode_q.push_back(2'd0);
    load_q.push_back({5'd0, 6'd1});
    press(1'b1, 1'b0, 8);
    chk("seq_run_back", o_run_en, 1);
  endtask

  task automatic test_simultaneous();
    cur_h = 5'd5;
    cur_m = 6'd20;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    mode_q.push_back(2'd2);
    press(1'b1, 1'b1, 8);
    chk("sim_mode", o_mode, 2);
    chk("sim_lh", o_load_hours, 5);
    mode_q.push_back(2'd0);
    load_q.push_back({5'd5, 6'd20});
    press(1'b1, 1'b0, 8);
  endtask

  task automatic test_blink();
    bit found;
    cur_h = 5'd10;
    cur_m = 6'd15;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    mode_q.push_back(2'd2);
    @(negedge clk);
    btn_mode = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (o_mode === 2'd2) found = 1'b1;
    end
    btn_mode = 1'b0;
    chk("blink_enter_timeout", int'(found), 1);
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (o_blink_m !== 1'((k / 50) % 2) || o_blink_h !== 1'b0) begin
        errors++;
        $display("FAIL blink_idle k=%0d: blink_m=%b blink_h=%b, expected %0d/0",
                 k, o_blink_m, o_blink_h, (k / 50) % 2);
      end
      @(negedge clk);
    end
    repeat (50) @(negedge clk);
    chk("blink_high", o_blink_m, 1);
    btn_inc = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (o_load_minutes !== 6'd15) found = 1'b1;
    end
    chk("blink_inc_timeout", int'(found), 1);
    chk("blink_inc_min", o_load_minutes, 16);
    btn_inc = 1'b0;
    for (int j = 0; j < 60; j++) begin
      checks++;
      if (o_blink_m !== (j >= 50)) begin
        errors++;
        $display("FAIL blink_restart j=%0d: blink_m=%b, expected %0d",
                 j, o_blink_m, int'(j >= 50));
      end
      @(negedge clk);
    end
    mode_q.push_back(2'd0);
    load_q.push_back({5'd10, 6'd16});
    press(1'b1, 1'b0, 8);
  endtask

  task automatic test_reset_mid_edit();
    cur_h = 5'd1;
    cur_m = 6'd2;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    mode_q.push_back(2'd2);
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    chk("mid_edit_min", o_load_minutes, 3);
    mode_q.push_back(2'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mode", o_mode, 0);
    chk("mid_rst_run_en", o_run_en, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_noload", o_load, 0);
  endtask

  task automatic test_auto_repeat();
    int exp_m;
`ifdef AUTO_REPEAT_EN
    exp_m = 6;
`else
    exp_m = 1;
`endif
    cur_h = 5'd4;
    cur_m = 6'd0;
    mode_q.push_back(2'd1);
    press(1'b1, 1'b0, 8);
    mode_q.push_back(2'd2);
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 100);
    chk("repeat_min", o_load_minutes, exp_m);
    mode_q.push_back(2'd0);
    load_q.push_back({5'd4, 6'(exp_m)});
    press(1'b1, 1'b0, 8);
  endtask

  initial begin
    fork
      mon_mode();
      mon_load();
    join_none
    test_reset();
    test_debounce();
    test_edit_sequence();
    test_simultaneous();
    test_blink();
    test_reset_mid_edit();
    test_auto_repeat();
    repeat (5) @(negedge clk);
    chk("mode_q_empty", mode_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-set controller for the binary clock. It debounces two push-buttons (mode, inc) and runs a RUN / SET_H / SET_M state machine. It freezes the clock counters while the user edits, then issues a one-cycle load of the edited hours/minutes back into the counter chain. It also drives per-field blink flags to the display path so the field being edited flashes. It runs on the same 100 Hz clk as the centisecond counter.

Parameters:
DEBOUNCE_CYCLES, 3, cycles a synchronised button level must be stable before it is accepted (1..15)
BLINK_PERIOD, 50, cycles per blink half-phase (2..127)
REPEAT_DELAY, 50, hold cycles before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_RATE, 10, cycles between auto-repeat increments (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock, 100 Hz tick domain
rst  in  1  reset, asynchronous, active-high
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
cur_hours  in  5  live hour count from clock counters, 0..23
cur_minutes  in  6  live minute count, 0..59
run_en  out  1  1 = clock counters advance; 0 = frozen
load  out  1  one-cycle strobe: counters take load_hours/load_minutes; seconds/centiseconds clear to 0
load_hours  out  5  edited hours
load_minutes  out  6  edited minutes
blink_h  out  1  1 = blank hour field this cycle
blink_m  out  1  1 = blank minute field this cycle
mode  out  2  0 = RUN, 1 = SET_H, 2 = SET_M; 3 never driven

Behaviour:
- Reset: state RUN, mode=0, run_en=1, load=0, load_hours=0, load_minutes=0, blink_h=0, blink_m=0. Clears synchronisers, debounce counters, debounced levels, blink counter/phase and repeat counter. Applies immediately and asynchronously.
- Each button path:
  - 2-flop synchroniser.
  - Debounce counter resets whenever the synchronised level differs from the accepted level.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level updates.
  - A press event is a 1-cycle pulse on a 0->1 change of the accepted level.
- Press latency: input held high from edge N gives the event pulse in cycle N+2+DEBOUNCE_CYCLES. State and registers update at the next edge.
- A pulse shorter than DEBOUNCE_CYCLES+1 cycles produces no event.
- Release produces no event.
- RUN:
  - run_en=1.
  - mode event -> SET_H; capture cur_hours into load_hours and cur_minutes into load_minutes; run_en=0 from that edge.
  - inc event ignored.
- SET_H:
  - inc event -> load_hours = (load_hours==23) ? 0 : load_hours+1.
  - mode event -> SET_M.
- SET_M:
  - inc event -> load_minutes = (load_minutes==59) ? 0 : load_minutes+1.
  - mode event -> RUN; load=1 for exactly that one cycle; run_en=1 from the following cycle.
- Simultaneous mode and inc events in the same cycle: mode wins and the inc is discarded.
- load_hours/load_minutes are registered and hold their value outside edits; they are only meaningful while load=1.
- Blink:
  - Counter runs 0..BLINK_PERIOD-1; phase toggles on wrap.
  - Counter and phase clear to 0 on every state transition and on every inc event, so an edited value is shown immediately.
  - blink_h = (state==SET_H) & phase; blink_m = (state==SET_M) & phase.
- Reset mid-edit discards edits: no load pulse, returns to RUN.
- Captured values outside range (hours>23, minutes>59): the next increment wraps them to 0.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while accepted inc stays high in SET_H/SET_M, an extra inc event fires REPEAT_DELAY cycles after the initial event, then every REPEAT_RATE cycles until release or state change. Each repeat event also clears blink.
- Undefined: exactly one inc event per press; REPEAT_DELAY/REPEAT_RATE unused, no repeat logic.

Test Plan:
1. Reset asserted mid-cycle -> run_en=1, load=0, mode=0, blink_h=blink_m=0 immediately, before the next clk edge.
2. In SET_H with load_hours=7, btn_inc high for 3 cycles (DEBOUNCE_CYCLES=3) -> load_hours stays 7. Then high for 10 cycles -> exactly one event at N+5, load_hours=8.
3. cur_hours=22, cur_minutes=58; mode, inc, inc, mode, inc, inc, inc, mode -> mode sequence 1,2,0; single-cycle load with load_hours=0, load_minutes=1; run_en low from first mode edge until the cycle after load.
4. SET_H with load_hours=5, mode and inc events in the same cycle -> mode=2, load_hours=5.
5. Idle 200 cycles in SET_M -> blink_m toggles every 50 cycles starting low, blink_h=0. An inc event restarts the phase low.
6. Reset during SET_M after edits -> no load pulse, mode=0, run_en=1. With AUTO_REPEAT_EN and inc held 100 cycles in SET_M from minutes=0 -> minutes=6 (1 initial + 5 repeats).
